// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// master: operand issue + result sink; slave: the adder.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ina;
    logic [WIDTH-1:0] inb;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, ina, inb, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum_out, carry_out, overflow
    );

    modport slave (
        input  in_valid, ina, inb, carry_in, sub, out_ready,
        output in_ready, out_valid, sum_out, carry_out, overflow
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry rippled
// between stages. Ports: clk, rst (sync, active-high), io_bus (slave).
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave io_bus
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad
        $error("pipe_adder: WIDTH must be a multiple of CHUNK");
    end

    // Stage registers. r_s[k] holds result slices 0..k (upper bits zero);
    // r_a/r_b carry the effective operands forward for later slices.
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic              r_ovf;

    // Per-stage inputs and slice arithmetic.
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_c;
    logic [WIDTH-1:0]  w_s     [STAGES];
    logic [WIDTH-1:0]  w_a     [STAGES];
    logic [WIDTH-1:0]  w_b     [STAGES];
    logic [CHUNK:0]    w_add   [STAGES];
    logic [WIDTH-1:0]  w_snext [STAGES];

    logic w_adv;
    logic w_cmsb;
    logic w_ovf;

    // Global stall: the whole pipe moves only if the output slot frees up.
    assign w_adv = !r_v[LAST] || io_bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        if (k == 0) begin : g_in
            // Subtract as A + ~B + ~borrow.
            assign w_a[k] = io_bus.ina;
            assign w_b[k] = io_bus.sub ? ~io_bus.inb : io_bus.inb;
            assign w_c[k] = io_bus.carry_in ^ io_bus.sub;
            assign w_s[k] = '0;
            assign w_v[k] = io_bus.in_valid;
        end else begin : g_pipe
            assign w_a[k] = r_a[k-1];
            assign w_b[k] = r_b[k-1];
            assign w_c[k] = r_c[k-1];
            assign w_s[k] = r_s[k-1];
            assign w_v[k] = r_v[k-1];
        end

        assign w_add[k] = {1'b0, w_a[k][k*CHUNK +: CHUNK]}
                        + {1'b0, w_b[k][k*CHUNK +: CHUNK]}
                        + (CHUNK+1)'(w_c[k]);

        // Slices above k are still zero in w_s, so OR inserts slice k.
        assign w_snext[k] = w_s[k]
                          | (WIDTH'(w_add[k][CHUNK-1:0]) << (k*CHUNK));
    end

    // Carry into the MSB recovered from the MSB sum bit.
    assign w_cmsb = w_a[LAST][WIDTH-1]
                  ^ w_b[LAST][WIDTH-1]
                  ^ w_add[LAST][CHUNK-1];
    assign w_ovf  = w_cmsb ^ w_add[LAST][CHUNK];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_s[k] <= '0;
            end
        end else if (w_adv) begin
            r_v <= w_v;
            for (int k = 0; k < STAGES; k++) begin
                if (w_v[k]) begin
                    r_s[k] <= w_snext[k];
                    r_c[k] <= w_add[k][CHUNK];
                end
            end
            if (w_v[LAST]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    // Operand forwarding needs no reset: only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_v[k]) begin
                    r_a[k] <= w_a[k];
                    r_b[k] <= w_b[k];
                end
            end
        end
    end

    assign io_bus.in_ready  = w_adv;
    assign io_bus.out_valid = r_v[LAST];
    assign io_bus.sum_out   = r_s[LAST];
    assign io_bus.carry_out = r_c[LAST];
    assign io_bus.overflow  = r_ovf;
endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: 32/8 pipe plus degenerate 4/4 instance.
// Drives and samples on the falling clock edge.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(32)) b32 ();
    pipe_adder_if #(.WIDTH(4))  b4 ();

    pipe_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b32)
    );

    pipe_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .io_bus (b4)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [33:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic ci,
                         input logic sb);
        b32.in_valid = v;
        b32.ina      = a;
        b32.inb      = b;
        b32.carry_in = ci;
        b32.sub      = sb;
    endtask

    // Reference: plain wide add, overflow from operand/result signs.
    function automatic logic [33:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic ci, input logic sb);
        logic [31:0] eb;
        logic [32:0] f;
        logic        ov;
        eb = sb ? ~b : b;
        f  = {1'b0, a} + {1'b0, eb} + {32'd0, sb ^ ci};
        ov = (a[31] == eb[31]) && (f[31] != a[31]);
        return {ov, f[32], f[31:0]};
    endfunction

    function automatic logic [33:0] obs32();
        return {b32.overflow, b32.carry_out, b32.sum_out};
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        rs;
        logic [33:0] e;
        int          sent;
        int          got;
        int          first_j;
        int          last_j;

        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        b32.out_ready = 1'b1;
        b4.in_valid   = 1'b0;
        b4.ina        = 4'd0;
        b4.inb        = 4'd0;
        b4.carry_in   = 1'b0;
        b4.sub        = 1'b0;
        b4.out_ready  = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_ovalid", 64'(b32.out_valid), 64'd0);
        chk("rst_outs", 64'(obs32()), 64'd0);
        chk("rst_iready", 64'(b32.in_ready), 64'd1);
        chk("rst4_ovalid", 64'(b4.out_valid), 64'd0);

        // Full ripple add (32) and degenerate single-stage add (4).
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        b4.in_valid = 1'b1;
        b4.ina      = 4'h9;
        b4.inb      = 4'h8;
        b4.carry_in = 1'b1;
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        b4.in_valid = 1'b0;
        chk("w4_ovalid", 64'(b4.out_valid), 64'd1);
        chk("w4_sum", 64'(b4.sum_out), 64'h2);
        chk("w4_cout", 64'(b4.carry_out), 64'd1);
        chk("w4_ovf", 64'(b4.overflow), 64'd1);
        chk("lat_ovalid1", 64'(b32.out_valid), 64'd0);
        step();
        chk("w4_bubble", 64'(b4.out_valid), 64'd0);
        step();
        chk("lat_ovalid3", 64'(b32.out_valid), 64'd0);
        step();
        chk("ripple_ovalid", 64'(b32.out_valid), 64'd1);
        chk("ripple_sum", 64'(b32.sum_out), 64'h0000_0000);
        chk("ripple_cout", 64'(b32.carry_out), 64'd1);
        chk("ripple_ovf", 64'(b32.overflow), 64'd0);

        // Signed overflow, then subtract with borrow.
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        chk("ovf_sum", 64'(b32.sum_out), 64'h8000_0000);
        chk("ovf_flag", 64'(b32.overflow), 64'd1);
        chk("ovf_cout", 64'(b32.carry_out), 64'd0);
        step();
        chk("sub_valid", 64'(b32.out_valid), 64'd1);
        chk("sub_sum", 64'(b32.sum_out), 64'hFFFF_FFFE);
        chk("sub_cout", 64'(b32.carry_out), 64'd0);
        chk("sub_ovf", 64'(b32.overflow), 64'd0);
        step();
        chk("bubble_ovalid", 64'(b32.out_valid), 64'd0);
        chk("bubble_hold", 64'(b32.sum_out), 64'hFFFF_FFFE);

        // Reset with two ops in flight.
        drive(1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mrst_ovalid", 64'(b32.out_valid), 64'd0);
        chk("mrst_outs", 64'(obs32()), 64'd0);
        chk("mrst_iready", 64'(b32.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mrst_quiet", 64'(b32.out_valid), 64'd0);
        end

        // Stream of 100 random ops, one per cycle.
        sent    = 0;
        got     = 0;
        first_j = -1;
        last_j  = -1;
        for (int j = 0; j < 200 && got < 100; j++) begin
            if (b32.out_valid) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream_res", 64'(obs32()), 64'(e));
                end
                if (first_j < 0) first_j = j;
                last_j = j;
                got++;
            end
            if (sent < 100) begin
                ra = $urandom();
                rb = $urandom();
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                drive(1'b1, ra, rb, rc, rs);
                q.push_back(model(ra, rb, rc, rs));
                sent++;
            end else begin
                drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
            step();
        end
        chk("stream_count", 64'(got), 64'd100);
        chk("stream_first", 64'(first_j), 64'd4);
        chk("stream_gapless", 64'(last_j), 64'd103);
        chk("stream_drained", 64'(q.size()), 64'd0);
        q.delete();

        // Backpressure with a full pipe.
        for (int i = 0; i < 4; i++) begin
            ra = 32'h1000_0000 * (i + 1) + 32'h0123_4567;
            rb = 32'h8765_4321 - 32'(i);
            rs = 1'(i & 1);
            drive(1'b1, ra, rb, 1'b1, rs);
            q.push_back(model(ra, rb, 1'b1, rs));
            step();
        end
        drive(1'b1, 32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0);
        b32.out_ready = 1'b0;
        #1;
        chk("bp_iready", 64'(b32.in_ready), 64'd0);
        e = q[0];
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_ovalid", 64'(b32.out_valid), 64'd1);
            chk("bp_stable", 64'(obs32()), 64'(e));
            chk("bp_iready", 64'(b32.in_ready), 64'd0);
        end
        b32.out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_ovalid", 64'(b32.out_valid), 64'd1);
            e = q.pop_front();
            chk("drain_res", 64'(obs32()), 64'(e));
            step();
        end
        chk("drain_empty", 64'(b32.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
